// File: rtl/frequency_analyzer_sequencer.sv
// Run controller for the pixel frequency analyzers: clear, timed enable window, snapshot, register drain, irq.
// Optional FREQ_SEQ_STATUS_WORD_EN appends a run-count status word after the result words.
module frequency_analyzer_sequencer #(
    parameter int unsigned CHANNELS      = 3,
    parameter int unsigned WINDOW_CYCLES = 100000000,
    parameter int unsigned REGISTER_BASE = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [CHANNELS*64-1:0]  results,
    input  logic                    register_ack,
    output logic                    analyzer_enable,
    output logic                    analyzer_clear_n,
    output logic [1:0]              register_operation,
    output logic [7:0]              register_number,
    output logic [31:0]             register_write,
    output logic                    busy,
    output logic                    done_irq
);

    localparam int unsigned RESULT_WORDS = 2 * CHANNELS;
`ifdef FREQ_SEQ_STATUS_WORD_EN
    localparam int unsigned WORDS = RESULT_WORDS + 1;
`else
    localparam int unsigned WORDS = RESULT_WORDS;
`endif
    localparam int unsigned K_W   = $clog2(WORDS + 1);
    localparam int unsigned BUF_W = 64 * CHANNELS;

    localparam logic [1:0]     OP_NONE  = 2'd0;
    localparam logic [1:0]     OP_WRITE = 2'd2;
    localparam logic [7:0]     BASE     = 8'(REGISTER_BASE);
    localparam logic [K_W-1:0] LAST     = K_W'(WORDS - 1);
    localparam logic [31:0]    WIN_LOAD = 32'(WINDOW_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, MEASURE, SETTLE, WRITE, DONE
    } state_t;

    state_t            state;
    logic [31:0]       counter;
    logic [K_W-1:0]    k;
    logic [BUF_W-1:0]  buffer;
`ifdef FREQ_SEQ_STATUS_WORD_EN
    logic [15:0]       run_count;
`endif

    logic [K_W-1:0]    k_next_c;
    logic [31:0]       next_word_c;

    assign k_next_c = k + 1'b1;

    // Data for the word following the one currently presented.
    always_comb begin
        next_word_c = 32'(buffer >> {k_next_c, 5'b0});
`ifdef FREQ_SEQ_STATUS_WORD_EN
        if (k_next_c == K_W'(RESULT_WORDS)) begin
            next_word_c = {8'h00, 8'(CHANNELS), run_count + 16'd1};
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            counter            <= '0;
            k                  <= '0;
            buffer             <= '0;
            analyzer_enable    <= 1'b0;
            analyzer_clear_n   <= 1'b1;
            register_operation <= OP_NONE;
            register_number    <= '0;
            register_write     <= '0;
            busy               <= 1'b0;
            done_irq           <= 1'b0;
`ifdef FREQ_SEQ_STATUS_WORD_EN
            run_count          <= '0;
`endif
        end else if (abort && state != IDLE) begin
            // Abort wins over arm and ack; snapshot is discarded.
            state              <= IDLE;
            counter            <= '0;
            k                  <= '0;
            analyzer_enable    <= 1'b0;
            analyzer_clear_n   <= 1'b1;
            register_operation <= OP_NONE;
            register_number    <= '0;
            register_write     <= '0;
            busy               <= 1'b0;
            done_irq           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm && !abort) begin
                        state            <= CLEAR;
                        busy             <= 1'b1;
                        analyzer_clear_n <= 1'b0;
                    end
                end
                CLEAR: begin
                    state            <= MEASURE;
                    analyzer_clear_n <= 1'b1;
                    analyzer_enable  <= 1'b1;
                    counter          <= WIN_LOAD;
                end
                MEASURE: begin
                    if (counter == 32'd0) begin
                        state           <= SETTLE;
                        analyzer_enable <= 1'b0;
                    end else begin
                        counter <= counter - 32'd1;
                    end
                end
                SETTLE: begin
                    state              <= WRITE;
                    buffer             <= results;
                    k                  <= '0;
                    register_operation <= OP_WRITE;
                    register_number    <= BASE;
                    register_write     <= results[31:0];
                end
                WRITE: begin
                    if (register_ack) begin
                        if (k == LAST) begin
                            state              <= DONE;
                            register_operation <= OP_NONE;
                            register_number    <= '0;
                            register_write     <= '0;
                            done_irq           <= 1'b1;
`ifdef FREQ_SEQ_STATUS_WORD_EN
                            run_count          <= run_count + 16'd1;
`endif
                        end else begin
                            k               <= k_next_c;
                            register_number <= BASE + 8'(k_next_c);
                            register_write  <= next_word_c;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done_irq <= 1'b0;
                    busy     <= 1'b0;
                    k        <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frequency_analyzer_sequencer.sv
// Directed bench for frequency_analyzer_sequencer (CHANNELS=3, WINDOW_CYCLES=10, REGISTER_BASE=1).
// Build with FREQ_SEQ_STATUS_WORD_EN to cover the status word as well.
module tb_frequency_analyzer_sequencer;

    localparam int unsigned CH   = 3;
    localparam int unsigned WIN  = 10;
    localparam int unsigned BASE = 1;
`ifdef FREQ_SEQ_STATUS_WORD_EN
    localparam int N_WORDS = 2 * CH + 1;
`else
    localparam int N_WORDS = 2 * CH;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              arm;
    logic              abort;
    logic [CH*64-1:0]  results;
    logic              register_ack;
    logic              analyzer_enable;
    logic              analyzer_clear_n;
    logic [1:0]        register_operation;
    logic [7:0]        register_number;
    logic [31:0]       register_write;
    logic              busy;
    logic              done_irq;

    int n_vec = 0;
    int n_err = 0;
    int runs  = 0;

    localparam logic [CH*64-1:0] PATTERN =
        {32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};

    frequency_analyzer_sequencer #(
        .CHANNELS      (CH),
        .WINDOW_CYCLES (WIN),
        .REGISTER_BASE (BASE)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .arm                (arm),
        .abort              (abort),
        .results            (results),
        .register_ack       (register_ack),
        .analyzer_enable    (analyzer_enable),
        .analyzer_clear_n   (analyzer_clear_n),
        .register_operation (register_operation),
        .register_number    (register_number),
        .register_write     (register_write),
        .busy               (busy),
        .done_irq           (done_irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int w);
        if (w < 2 * CH) return 32'h11 * (w + 1);
        return {8'h00, 8'(CH), 16'(runs + 1)};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_en"},   {31'd0, analyzer_enable}, 32'd0);
        check({tag, "_clrn"}, {31'd0, analyzer_clear_n}, 32'd1);
        check({tag, "_op"},   {30'd0, register_operation}, 32'd0);
        check({tag, "_irq"},  {31'd0, done_irq}, 32'd0);
    endtask

    // One run from arm; optional stall, snapshot corruption, arm pokes, abort-with-ack on a word.
    task automatic run(input int stall_word, input int stall_cycles, input bit corrupt,
                       input bit poke_arm, input int abort_word);
        int hold;
        results = PATTERN;
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd1);
        check("clr_n",    {31'd0, analyzer_clear_n}, 32'd0);
        check("clr_en",   {31'd0, analyzer_enable}, 32'd0);
        for (int i = 0; i < int'(WIN); i++) begin
            step();
            arm = (poke_arm && i == 3);
            check("meas_en",   {31'd0, analyzer_enable}, 32'd1);
            check("meas_clrn", {31'd0, analyzer_clear_n}, 32'd1);
            check("meas_op",   {30'd0, register_operation}, 32'd0);
        end
        step();
        arm = 1'b0;
        check("settle_en",   {31'd0, analyzer_enable}, 32'd0);
        check("settle_op",   {30'd0, register_operation}, 32'd0);
        check("settle_busy", {31'd0, busy}, 32'd1);
        for (int w = 0; w < N_WORDS; w++) begin
            hold = (w == stall_word) ? stall_cycles + 1 : 1;
            for (int c = 0; c < hold; c++) begin
                step();
                register_ack = (c == hold - 1);
                if (corrupt && w == 1) results = '1;
                arm   = (poke_arm && w == 2 && c == 0);
                abort = (w == abort_word);
                check("wr_op",   {30'd0, register_operation}, 32'd2);
                check("wr_num",  {24'd0, register_number}, 32'(BASE + w));
                check("wr_data", register_write, exp_word(w));
                check("wr_irq",  {31'd0, done_irq}, 32'd0);
            end
            if (w == abort_word) begin
                step();
                abort = 1'b0;
                arm   = 1'b0;
                check_idle("abort_ack");
                step();
                check_idle("abort_ack2");
                results = PATTERN;
                return;
            end
        end
        step();
        arm = poke_arm;
        check("done_irq",  {31'd0, done_irq}, 32'd1);
        check("done_op",   {30'd0, register_operation}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd1);
        runs++;
        step();
        arm = 1'b0;
        check_idle("post_done");
        step();
        check_idle("post_done2");
        results = PATTERN;
    endtask

    initial begin
        reset        = 1'b1;
        arm          = 1'b0;
        abort        = 1'b0;
        results      = PATTERN;
        register_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_idle("reset");
        check("reset_num",  {24'd0, register_number}, 32'd0);
        check("reset_data", register_write, 32'd0);

        // abort without arm must not start anything
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort_idle");

        run(-1, 0, 1'b0, 1'b0, -1);   // full run, ack held
        run(2, 3, 1'b0, 1'b0, -1);    // back-pressure on word 2
        run(-1, 0, 1'b1, 1'b0, -1);   // snapshot isolation
        run(-1, 0, 1'b0, 1'b0, 4);    // abort together with ack on word 4
        run(-1, 0, 1'b0, 1'b1, -1);   // arm pokes during MEASURE, WRITE, DONE

        // abort during MEASURE
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        step();
        check("abm_en", {31'd0, analyzer_enable}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort_meas");
        for (int i = 0; i < int'(WIN) + 4; i++) begin
            step();
            check("abm_op",  {30'd0, register_operation}, 32'd0);
            check("abm_irq", {31'd0, done_irq}, 32'd0);
        end

        // reset clears the run counter
        reset = 1'b1;
        step();
        reset = 1'b0;
        runs = 0;
        check_idle("reset2");
        run(-1, 0, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
